bytewrite_tdp_ram_fwd: RTL and testbench
========================================

# bytewrite_tdp_ram_fwd

Parametrised column-write RAM with two ports: port A does read/write with per-column enables, port B is read-only. It is the next-generation memory primitive for the model/counter tables. Compared with the current byte-write RAM it adds configurable column width, selectable port-A read mode, an optional output register, same-cycle A→B write forwarding, output valid strobes, and a hardware clear sequence that zeroes the whole array after reset.

## Interface
- NUM_COL, 4, number of write columns per word
- COL_WIDTH, 8, bits per column
- ADDR_WIDTH, 12, address bits; depth = 2**ADDR_WIDTH
- DATA_WIDTH, NUM_COL*COL_WIDTH, word width (derived, not overridden)
- OUT_REG, 0, 1 adds an output pipeline register on both ports
- WRITE_FIRST, 0, port A read mode: 0 returns old word, 1 returns the merged new word
- clk  in  1  sole clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high
- init_busy  out  1  high while the clear sequence runs
- ena  in  1  port A enable
- wea  in  NUM_COL  port A column write enables
- addra  in  ADDR_WIDTH  port A address
- dina  in  DATA_WIDTH  port A write data; column i = dina[i*COL_WIDTH +: COL_WIDTH]
- doa  out  DATA_WIDTH  port A read data
- doa_valid  out  1  doa carries the result of an accepted access
- enb  in  1  port B enable
- addrb  in  ADDR_WIDTH  port B address
- dob  out  DATA_WIDTH  port B read data
- dob_valid  out  1  dob carries the result of an accepted access

## Operation
- FSM has two states: CLEAR and READY. Reset forces CLEAR, clear counter 0, doa/dob/pipeline registers 0, valids 0, init_busy 1.
- CLEAR:
  - Each cycle writes all-zero to ram[counter], then increments the counter.
  - After writing address 2**ADDR_WIDTH-1, the FSM moves to READY. The counter does not wrap back into CLEAR.
  - ena/enb are ignored. No array write from port A occurs, valids stay 0, and doa/dob hold 0.
- READY, port A (ena=1):
  - Each column i with wea[i]=1 takes dina column i. Other columns are unchanged.
  - Read data:
    - WRITE_FIRST=0: the pre-write word.
    - WRITE_FIRST=1: the post-write merged word.
    - wea=0: the stored word in both modes.
- READY, port B (enb=1): reads ram[addrb].
- Collision (ena & enb & addra==addrb & |wea): dob returns the post-write merged word, independent of WRITE_FIRST. Columns with wea=0 come from the old word.
- ena=0 / enb=0: the corresponding data output holds its last value and its valid is 0 for that result slot.
- Reset asserted mid-CLEAR or mid-READY immediately returns to the reset state and restarts the clear from address 0. Array contents during reset are don't-care; they are zero once CLEAR completes.

## Timing
- Read latency L = 1 + OUT_REG cycles from the accepting edge to data on doa/dob.
- A valid pulse accompanies each result, aligned with the data (cycle L after acceptance).
- Back-to-back accesses are accepted every cycle on both ports; throughput is 1 per port per cycle.
- Port A write is visible to any read accepted on the following edge or later, on either port. Same-edge visibility is given only by the forwarding rule above.
- CLEAR lasts exactly 2**ADDR_WIDTH cycles after reset deassertion. init_busy falls in the cycle after the last clear write, and the first access is accepted on that edge.
- With OUT_REG=1, the output register only loads when the stage-1 result is valid. Otherwise it holds.

## Test plan
- Clear:
  - Stimulus: ADDR_WIDTH=4; deassert reset; count the cycles init_busy is high; then read addresses 0 and 15 on port B.
  - Required: init_busy is high for exactly 16 cycles; both reads return 0.
  - Port A also writes 0xFFFFFFFF during CLEAR; required: memory is still 0 after CLEAR.
- Column merge:
  - Stimulus: write 0x11223344 to addr 5 with wea=1111, then 0xAABBCCDD with wea=0101; read addr 5 on port B.
  - Required: dob = 0x11BB33DD with dob_valid aligned at L.
- Read mode:
  - Stimulus: addr 7 holds 0x0; write 0xCAFEF00D with wea=1111 on port A.
  - Required: WRITE_FIRST=0 gives doa=0x00000000; WRITE_FIRST=1 gives doa=0xCAFEF00D.
- Collision forwarding:
  - Stimulus: addr 9 holds 0x01020304; in the same cycle, A writes 0xFFEEDDCC with wea=1000 and B reads addr 9.
  - Required: dob = 0xFF020304.
- Latency/hold with OUT_REG=1:
  - Stimulus: a burst of 4 reads, then enb=0.
  - Required: results appear in order 2 cycles after each accept; dob holds the last value; dob_valid is 0 after the burst drains.
- Reset mid-operation:
  - Stimulus: assert reset asynchronously during CLEAR (counter=6) and again during READY traffic.
  - Required: outputs are 0 immediately; CLEAR restarts from address 0 and takes the full 2**ADDR_WIDTH cycles; previously written data reads back 0.

Source files
------------

// File: rtl/bytewrite_tdp_ram_fwd.sv
`default_nettype none
// ============================================================================
// Module   : bytewrite_tdp_ram_fwd
// Brief    : Column-write RAM. Port A is read/write with per-column enables,
//            port B is read-only. Same-cycle A->B write forwarding, optional
//            output register, valid strobes, and a post-reset clear sweep.
// Revision : 1.0 - initial release
// ============================================================================
module bytewrite_tdp_ram_fwd #(
  parameter int NUM_COL     = 4,
  parameter int COL_WIDTH   = 8,
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = NUM_COL * COL_WIDTH,
  parameter int OUT_REG     = 0,
  parameter int WRITE_FIRST = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  init_busy,
  input  logic                  ena,
  input  logic [NUM_COL-1:0]    wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dina,
  output logic [DATA_WIDTH-1:0] doa,
  output logic                  doa_valid,
  input  logic                  enb,
  input  logic [ADDR_WIDTH-1:0] addrb,
  output logic [DATA_WIDTH-1:0] dob,
  output logic                  dob_valid
);

  localparam int                    c_DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = '1;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    w_ready;
  logic [ADDR_WIDTH-1:0]   r_clr_addr;

  logic [DATA_WIDTH-1:0]   r_mem [c_DEPTH];

  logic [NUM_COL-1:0]      w_wr_en;
  logic [ADDR_WIDTH-1:0]   w_wr_addr;
  logic [DATA_WIDTH-1:0]   w_wr_data;

  logic                    w_a_acc;
  logic                    w_b_acc;
  logic                    w_fwd;
  logic [DATA_WIDTH-1:0]   w_a_old;
  logic [DATA_WIDTH-1:0]   w_a_new;
  logic [DATA_WIDTH-1:0]   w_b_old;
  logic [DATA_WIDTH-1:0]   w_a_rd;
  logic [DATA_WIDTH-1:0]   w_b_rd;

  logic [DATA_WIDTH-1:0]   r_a_s1;
  logic                    r_a_s1_vld;
  logic [DATA_WIDTH-1:0]   r_b_s1;
  logic                    r_b_s1_vld;

  // State register: reset always restarts the clear sweep
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= CLEAR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and status decode; leave CLEAR right after the last address is zeroed
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    init_busy   = 1'b1;
    case (r_state)
      CLEAR: begin
        if (r_clr_addr == c_LAST_ADDR) begin
          w_state_nxt = READY;
        end
      end
      READY: begin
        w_ready   = 1'b1;
        init_busy = 1'b0;
      end
      default: begin
        w_state_nxt = CLEAR;
      end
    endcase
  end

  // Clear address counter; its wrap after the last address is harmless since READY is terminal
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clr_addr <= '0;
    end else if (r_state == CLEAR) begin
      r_clr_addr <= r_clr_addr + 1'b1;
    end
  end

  // Accept qualifiers: nothing on either port is taken while clearing
  assign w_a_acc = w_ready & ena;
  assign w_b_acc = w_ready & enb;

  // Single write port shared by the clear sweep and port A
  always_comb begin
    w_wr_en   = '1;
    w_wr_addr = r_clr_addr;
    w_wr_data = '0;
    if (w_ready) begin
      w_wr_en   = wea & {NUM_COL{ena}};
      w_wr_addr = addra;
      w_wr_data = dina;
    end
  end

  // Array update, one column slice per enable bit
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_COL; i++) begin
      if (w_wr_en[i]) begin
        r_mem[w_wr_addr][i*COL_WIDTH +: COL_WIDTH] <= w_wr_data[i*COL_WIDTH +: COL_WIDTH];
      end
    end
  end

  assign w_a_old = r_mem[addra];
  assign w_b_old = r_mem[addrb];

  // Merged post-write word: written columns from dina, the rest from the stored word
  for (genvar c = 0; c < NUM_COL; c++) begin : g_merge
    assign w_a_new[c*COL_WIDTH +: COL_WIDTH] =
      wea[c] ? dina[c*COL_WIDTH +: COL_WIDTH] : w_a_old[c*COL_WIDTH +: COL_WIDTH];
  end

  // Port B sees the merged word when port A writes the same address on the same edge
  assign w_fwd  = w_a_acc & w_b_acc & (|wea) & (addra == addrb);
  assign w_a_rd = (WRITE_FIRST != 0) ? w_a_new : w_a_old;
  assign w_b_rd = w_fwd ? w_a_new : w_b_old;

  // Stage-1 read registers: data loads only on an accepted access, otherwise holds
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a_s1     <= '0;
      r_a_s1_vld <= 1'b0;
      r_b_s1     <= '0;
      r_b_s1_vld <= 1'b0;
    end else begin
      r_a_s1_vld <= w_a_acc;
      r_b_s1_vld <= w_b_acc;
      if (w_a_acc) begin
        r_a_s1 <= w_a_rd;
      end
      if (w_b_acc) begin
        r_b_s1 <= w_b_rd;
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] r_a_s2;
    logic                  r_a_s2_vld;
    logic [DATA_WIDTH-1:0] r_b_s2;
    logic                  r_b_s2_vld;

    // Output stage: follows stage-1 valid, holds data across idle slots
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_a_s2     <= '0;
        r_a_s2_vld <= 1'b0;
        r_b_s2     <= '0;
        r_b_s2_vld <= 1'b0;
      end else begin
        r_a_s2_vld <= r_a_s1_vld;
        r_b_s2_vld <= r_b_s1_vld;
        if (r_a_s1_vld) begin
          r_a_s2 <= r_a_s1;
        end
        if (r_b_s1_vld) begin
          r_b_s2 <= r_b_s1;
        end
      end
    end

    assign doa       = r_a_s2;
    assign doa_valid = r_a_s2_vld;
    assign dob       = r_b_s2;
    assign dob_valid = r_b_s2_vld;
  end else begin : g_no_out_reg
    assign doa       = r_a_s1;
    assign doa_valid = r_a_s1_vld;
    assign dob       = r_b_s1;
    assign dob_valid = r_b_s1_vld;
  end

endmodule
`default_nettype wire

// File: tb/tb_bytewrite_tdp_ram_fwd.sv
`default_nettype none
// ============================================================================
// Module   : tb_bytewrite_tdp_ram_fwd
// Brief    : Scoreboard bench driving two instances in lockstep:
//            u_dut0 (OUT_REG=0, WRITE_FIRST=0), u_dut1 (OUT_REG=1, WRITE_FIRST=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bytewrite_tdp_ram_fwd;

  localparam int c_AW = 4;
  localparam int c_DW = 32;

  typedef struct packed {
    logic [31:0] data;
    int unsigned due;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              ena;
  logic [3:0]        wea;
  logic [c_AW-1:0]   addra;
  logic [c_DW-1:0]   dina;
  logic              enb;
  logic [c_AW-1:0]   addrb;

  logic              init_busy0, init_busy1;
  logic [c_DW-1:0]   doa0, dob0, doa1, dob1;
  logic              doa_valid0, dob_valid0, doa_valid1, dob_valid1;

  int                n_checks = 0;
  int                n_fail   = 0;
  int unsigned       cyc      = 0;
  logic              ready    = 1'b0;
  logic [31:0]       mdl_mem [16];
  exp_t              exp_q [4][$];
  logic [31:0]       last_val [4];
  string             port_name [4] = '{"a0", "b0", "a1", "b1"};

  logic [3:0]        mon_vld;
  logic [31:0]       mon_dat [4];
  exp_t              mon_e;

  bytewrite_tdp_ram_fwd #(
    .NUM_COL(4), .COL_WIDTH(8), .ADDR_WIDTH(c_AW), .OUT_REG(0), .WRITE_FIRST(0)
  ) u_dut0 (
    .clk(clk), .reset(reset), .init_busy(init_busy0),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .doa(doa0), .doa_valid(doa_valid0),
    .enb(enb), .addrb(addrb), .dob(dob0), .dob_valid(dob_valid0)
  );

  bytewrite_tdp_ram_fwd #(
    .NUM_COL(4), .COL_WIDTH(8), .ADDR_WIDTH(c_AW), .OUT_REG(1), .WRITE_FIRST(1)
  ) u_dut1 (
    .clk(clk), .reset(reset), .init_busy(init_busy1),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .doa(doa1), .doa_valid(doa_valid1),
    .enb(enb), .addrb(addrb), .dob(dob1), .dob_valid(dob_valid1)
  );

  always #5 clk = ~clk;

  // Edge counter used to stamp expected result times
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, want, $time);
    end
  endtask

  task automatic set_idle();
    ena = 1'b0; wea = 4'h0; addra = '0; dina = '0; enb = 1'b0; addrb = '0;
  endtask

  // One access slot; expectations are pushed when the slot is accepted by READY DUTs
  task automatic drive(input logic a_en, input logic [3:0] a_we, input logic [3:0] a_ad,
                       input logic [31:0] a_d, input logic b_en, input logic [3:0] b_ad);
    logic [31:0] old_w, new_w, b_w;
    int unsigned acc;
    @(posedge clk);
    #1;
    ena = a_en; wea = a_we; addra = a_ad; dina = a_d; enb = b_en; addrb = b_ad;
    if (ready) begin
      acc   = cyc + 1;
      old_w = mdl_mem[a_ad];
      for (int c = 0; c < 4; c++)
        new_w[c*8 +: 8] = a_we[c] ? a_d[c*8 +: 8] : old_w[c*8 +: 8];
      if (a_en) begin
        exp_q[0].push_back('{data: old_w, due: acc});
        exp_q[2].push_back('{data: new_w, due: acc + 1});
      end
      if (b_en) begin
        b_w = (a_en && (|a_we) && (a_ad == b_ad)) ? new_w : mdl_mem[b_ad];
        exp_q[1].push_back('{data: b_w, due: acc});
        exp_q[3].push_back('{data: b_w, due: acc + 1});
      end
      if (a_en) mdl_mem[a_ad] = new_w;
    end
  endtask

  // Asynchronous reset between edges; port A tries to write ones meanwhile
  task automatic assert_reset();
    @(posedge clk);
    #3;
    reset = 1'b1;
    ready = 1'b0;
    for (int p = 0; p < 4; p++) begin
      exp_q[p].delete();
      last_val[p] = '0;
    end
    for (int i = 0; i < 16; i++) mdl_mem[i] = '0;
    ena = 1'b1; wea = 4'hF; addra = 4'd3; dina = 32'hFFFF_FFFF; enb = 1'b1; addrb = 4'd3;
    #1;
    check("rst_doa0", doa0, 32'h0);
    check("rst_dob0", dob0, 32'h0);
    check("rst_doa1", doa1, 32'h0);
    check("rst_dob1", dob1, 32'h0);
    check("rst_valids", {doa_valid0, dob_valid0, doa_valid1, dob_valid1}, 32'h0);
    check("rst_busy", {init_busy0, init_busy1}, 32'h3);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #3;
    reset = 1'b0;
  endtask

  // Counts init_busy-high cycles after release (stimulus still hammers port A)
  task automatic count_busy();
    int n0 = 0;
    int n1 = 0;
    for (int k = 0; k < 40; k++) begin
      for (int j = 0; j < 4; j++) addra = 4'($urandom_range(0, 15));
      @(negedge clk);
      if (init_busy0) n0++;
      if (init_busy1) n1++;
      if (!init_busy0 && !init_busy1) break;
    end
    set_idle();
    check("busy_cycles0", n0, 16);
    check("busy_cycles1", n1, 16);
    ready = 1'b1;
  endtask

  task automatic read_all_zero();
    for (int i = 0; i < 16; i++) drive(1'b1, 4'h0, 4'(i), 32'h0, 1'b1, 4'(15 - i));
  endtask

  // Scoreboard monitor: pop on valid, otherwise the output must hold its last value
  always @(negedge clk) begin
    mon_vld    = {dob_valid1, doa_valid1, dob_valid0, doa_valid0};
    mon_dat[0] = doa0; mon_dat[1] = dob0; mon_dat[2] = doa1; mon_dat[3] = dob1;
    for (int p = 0; p < 4; p++) begin
      if (mon_vld[p]) begin
        if (exp_q[p].size() == 0) begin
          check({"unexp_valid_", port_name[p]}, 32'h1, 32'h0);
        end else begin
          mon_e = exp_q[p].pop_front();
          check({"data_", port_name[p]}, mon_dat[p], mon_e.data);
          check({"lat_", port_name[p]}, cyc, mon_e.due);
          last_val[p] = mon_e.data;
        end
      end else begin
        check({"hold_", port_name[p]}, mon_dat[p], last_val[p]);
      end
    end
  end

  initial begin
    for (int p = 0; p < 4; p++) last_val[p] = '0;
    for (int i = 0; i < 16; i++) mdl_mem[i] = '0;
    set_idle();
    reset = 1'b0;
    #1;
    reset = 1'b1;
    ena = 1'b1; wea = 4'hF; dina = 32'hFFFF_FFFF; enb = 1'b1;
    release_reset();
    count_busy();

    // Memory must be zero everywhere despite port A writes during the sweep
    read_all_zero();

    // Column merge
    drive(1'b1, 4'hF, 4'd5, 32'h1122_3344, 1'b0, 4'd0);
    drive(1'b1, 4'h5, 4'd5, 32'hAABB_CCDD, 1'b0, 4'd0);
    drive(1'b0, 4'h0, 4'd0, 32'h0,         1'b1, 4'd5);

    // Read mode on a zero word
    drive(1'b1, 4'hF, 4'd7, 32'hCAFE_F00D, 1'b0, 4'd0);
    drive(1'b0, 4'h0, 4'd0, 32'h0,         1'b0, 4'd0);

    // Collision forwarding on a single column
    drive(1'b1, 4'hF, 4'd9, 32'h0102_0304, 1'b0, 4'd0);
    drive(1'b0, 4'h0, 4'd0, 32'h0,         1'b0, 4'd0);
    drive(1'b1, 4'h8, 4'd9, 32'hFFEE_DDCC, 1'b1, 4'd9);
    drive(1'b0, 4'h0, 4'd0, 32'h0,         1'b1, 4'd9);

    // Read burst then idle to observe drain and hold
    drive(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd5);
    drive(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd7);
    drive(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd9);
    drive(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd0);
    repeat (4) drive(1'b0, 4'h0, 4'd0, 32'h0, 1'b0, 4'd0);

    // Random traffic with frequent same-address collisions
    for (int n = 0; n < 150; n++) begin
      logic [3:0] ra;
      ra = 4'($urandom_range(0, 15));
      drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), ra, $urandom,
            1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? ra : 4'($urandom_range(0, 15)));
    end

    // Reset during READY traffic: earlier data must be gone after the new sweep
    drive(1'b1, 4'hF, 4'd3, 32'h5A5A_A5A5, 1'b1, 4'd5);
    assert_reset();
    release_reset();
    count_busy();
    read_all_zero();

    // Reset during CLEAR with the counter at 6
    assert_reset();
    release_reset();
    repeat (5) @(posedge clk);
    assert_reset();
    release_reset();
    count_busy();
    read_all_zero();

    repeat (4) drive(1'b0, 4'h0, 4'd0, 32'h0, 1'b0, 4'd0);
    @(negedge clk);
    for (int p = 0; p < 4; p++) check({"drained_", port_name[p]}, exp_q[p].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
